mult_div_unit: RTL



---
 rtl/mult_div_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: shift-add MULT/MULTU, restoring DIV/DIVU, HI/LO results.
// Optional mthi/mtlo write port enabled by defining MDU_MTHILO_EN.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
`ifdef MDU_MTHILO_EN
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               is_div_q;
  logic               dz_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic [WIDTH-1:0]   divisor_q;  // multiplicand for multiply, divisor for divide
  logic [WIDTH-1:0]   acc_q;      // product high half / partial remainder
  logic [WIDTH-1:0]   mq_q;       // multiplier / dividend-then-quotient

  // Operand decode and magnitude conversion at issue
  logic               op_div;
  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  always_comb begin
    op_div    = op[1];
    op_signed = ~op[0];
    a_neg     = op_signed & operand_a[WIDTH-1];
    b_neg     = op_signed & operand_b[WIDTH-1];
    a_mag     = a_neg ? ('0 - operand_a) : operand_a;
    b_mag     = b_neg ? ('0 - operand_b) : operand_b;
  end

  // One iteration step; all arithmetic carried at WIDTH+1 bits
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   mq_d;

  always_comb begin
    addend  = mq_q[0] ? {1'b0, divisor_q} : '0;
    sum     = {1'b0, acc_q} + addend;
    shifted = {acc_q, mq_q[WIDTH-1]};
    diff    = shifted - {1'b0, divisor_q};
    acc_d   = acc_q;
    mq_d    = mq_q;
    if (is_div_q) begin
      if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = shifted[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = sum[WIDTH:1];
      mq_d  = {sum[0], mq_q[WIDTH-1:1]};
    end
  end

  // Sign fixup of the finished magnitudes
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;

  always_comb begin
    prod     = {acc_q, mq_q};
    prod_fix = neg_res_q ? ('0 - prod) : prod;
    quo_fix  = neg_res_q ? ('0 - mq_q) : mq_q;
    rem_fix  = neg_rem_q ? ('0 - acc_q) : acc_q;
    hi_d     = prod_fix[2*WIDTH-1:WIDTH];
    lo_d     = prod_fix[WIDTH-1:0];
    if (dz_q) begin
      hi_d = mq_q;
      lo_d = '1;
    end else if (is_div_q) begin
      hi_d = rem_fix;
      lo_d = quo_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      divisor_q  <= '0;
      acc_q      <= '0;
      mq_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            is_div_q  <= op_div;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            acc_q     <= '0;
            if (op_div && (operand_b == '0)) begin
              // Divide by zero skips the iterations; raw dividend goes to HI
              dz_q    <= 1'b1;
              mq_q    <= operand_a;
              state_q <= FINISH;
            end else begin
              dz_q      <= 1'b0;
              mq_q      <= op_div ? a_mag : b_mag;
              divisor_q <= op_div ? b_mag : a_mag;
              state_q   <= CALC;
            end
          end
`ifdef MDU_MTHILO_EN
          else begin
            if (hilo_we[1]) hi_q <= hilo_wdata;
            if (hilo_we[0]) lo_q <= hilo_wdata;
          end
`endif
        end
        CALC: begin
          acc_q <= acc_d;
          mq_q  <= mq_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          hi_q       <= hi_d;
          lo_q       <= lo_d;
          div_zero_q <= dz_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
